// File: rtl/uart_cmd_assembler_if.sv
// uart_cmd_assembler_if
//   Bundles the byte-side and command-side handshakes of uart_cmd_assembler.
//
//   Handshake semantics (both sides are level/acknowledge style):
//     - rx_rdy is a level held by the receiver until it sees clr_rx_rdy; a byte
//       is transferred on the rising clk edge of any cycle with rx_rdy=1, and
//       clr_rx_rdy=1 in that same cycle tells the receiver to drop rx_rdy.
//     - cmd_rdy is a level held by the assembler until the consumer pulses
//       clr_cmd_rdy; cmd is valid whenever cmd_rdy=1.
//
//   Signals:
//     rx_data[7:0], rx_rdy   : byte stream from the UART receiver
//     clr_rx_rdy             : byte acknowledge back to the receiver
//     cmd[15:0], cmd_rdy     : assembled command and its valid flag
//     clr_cmd_rdy            : consumer acknowledge
//     cmd_ovr                : sticky overrun flag
//     cmd_to                 : one-cycle inter-byte timeout pulse
//     state_dbg              : FSM state (0 = waiting for high byte, 1 = low)
//
//   Modports: master = environment (receiver + consumer), slave = assembler.
interface uart_cmd_assembler_if;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        cmd_ovr;
  logic        cmd_to;
  logic        state_dbg;

  modport master (
    output rx_data, rx_rdy, clr_cmd_rdy,
    input  clr_rx_rdy, cmd, cmd_rdy, cmd_ovr, cmd_to, state_dbg
  );

  modport slave (
    input  rx_data, rx_rdy, clr_cmd_rdy,
    output clr_rx_rdy, cmd, cmd_rdy, cmd_ovr, cmd_to, state_dbg
  );
endinterface

// File: rtl/uart_cmd_assembler.sv
// uart_cmd_assembler
//   Assembles pairs of received UART bytes (high byte first) into 16-bit
//   commands, acknowledging each byte to the receiver, holding the finished
//   command with a cmd_rdy/clr_cmd_rdy handshake and flagging overruns.
//
//   Optional build macro: CMD_TIMEOUT_EN
//     When defined, a stray high byte is discarded after TIMEOUT clocks in the
//     LOW state without a second byte, and cmd_to pulses for one cycle.
//     When undefined, LOW waits indefinitely and cmd_to is tied to 0.
//
//   Parameters:
//     TIMEOUT : clocks allowed in LOW before discarding (CMD_TIMEOUT_EN only)
//   Ports:
//     clk     : clock
//     rst_n   : asynchronous active-low reset
//     bus     : uart_cmd_assembler_if.slave (see interface file for signals)
module uart_cmd_assembler #(
  parameter int TIMEOUT = 52080
) (
  input logic                  clk,
  input logic                  rst_n,
  uart_cmd_assembler_if.slave  bus
);

  typedef enum logic {HIGH = 1'b0, LOW = 1'b1} state_t;

  state_t      state;
  logic [7:0]  hi_byte;
  logic [15:0] cmd_q;
  logic        cmd_rdy_q;
  logic        cmd_ovr_q;

`ifdef CMD_TIMEOUT_EN
  localparam logic [15:0] TERM_CNT = 16'(TIMEOUT - 1);
  logic [15:0] to_cnt;
  logic        cmd_to_q;
`endif

  // The receiver drops rx_rdy on the edge after it sees the acknowledge, so
  // echoing the level acknowledges every byte in the cycle it is sampled.
  assign bus.clr_rx_rdy = bus.rx_rdy & rst_n;

  assign bus.cmd       = cmd_q;
  assign bus.cmd_rdy   = cmd_rdy_q;
  assign bus.cmd_ovr   = cmd_ovr_q;
  assign bus.state_dbg = (state == LOW);

`ifdef CMD_TIMEOUT_EN
  assign bus.cmd_to = cmd_to_q;
`else
  assign bus.cmd_to = 1'b0;
`endif

  // High-byte holding register; a stale value is never used because LOW is
  // only entered by loading it.
  always_ff @(posedge clk) begin
    if (state == HIGH && bus.rx_rdy) begin
      hi_byte <= bus.rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HIGH;
      cmd_q     <= 16'h0000;
      cmd_rdy_q <= 1'b0;
      cmd_ovr_q <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      to_cnt    <= 16'd0;
      cmd_to_q  <= 1'b0;
`endif
    end else begin
`ifdef CMD_TIMEOUT_EN
      cmd_to_q <= 1'b0;
`endif
      // Clear first so that a command completing in the same cycle wins.
      if (bus.clr_cmd_rdy) begin
        cmd_rdy_q <= 1'b0;
        cmd_ovr_q <= 1'b0;
      end

      case (state)
        HIGH: begin
          if (bus.rx_rdy) begin
            state <= LOW;
`ifdef CMD_TIMEOUT_EN
            to_cnt <= 16'd0;
`endif
          end
        end

        LOW: begin
          if (bus.rx_rdy) begin
            cmd_q     <= {hi_byte, bus.rx_data};
            cmd_rdy_q <= 1'b1;
            // cmd_ovr can only be set while cmd_rdy is set, so the overrun
            // condition alone decides the new value.
            if (cmd_rdy_q) begin
              cmd_ovr_q <= 1'b1;
            end
            state <= HIGH;
`ifdef CMD_TIMEOUT_EN
          end else if (to_cnt == TERM_CNT) begin
            state    <= HIGH;
            to_cnt   <= 16'd0;
            cmd_to_q <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 16'd1;
`endif
          end
        end

        default: state <= HIGH;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// tb_uart_cmd_assembler
//   Directed and randomized stimulus for uart_cmd_assembler. A reference model
//   tracks bytes, commands and timeouts by edge number; completed commands go
//   into an expected queue that a negedge monitor drains.
module tb_uart_cmd_assembler;

  localparam int TB_TIMEOUT = 8;
`ifdef CMD_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  uart_cmd_assembler_if bus_if();

  uart_cmd_assembler #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  // ---------------- reference model state ----------------
  bit          have_hi;
  logic [7:0]  m_hi;
  logic [15:0] m_cmd;
  bit          m_rdy;
  bit          m_ovr;
  int          hi_edge;
  int          exp_to_edge = -1;
  logic [16:0] exp_q[$];   // {ovr, cmd}

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one byte for one cycle (receiver drops rdy right after the ack).
  task automatic send_byte(input logic [7:0] b, input bit clr);
    bus_if.rx_data     = b;
    bus_if.rx_rdy      = 1'b1;
    bus_if.clr_cmd_rdy = clr;
    @(posedge clk);
    #1;
    bus_if.rx_rdy      = 1'b0;
    bus_if.clr_cmd_rdy = 1'b0;
    // A held high byte survives only if the second byte arrives within
    // TIMEOUT edges of it.
    if (TO_ON && have_hi && (cyc - hi_edge) > TB_TIMEOUT) have_hi = 1'b0;
    if (!have_hi) begin
      have_hi     = 1'b1;
      m_hi        = b;
      hi_edge     = cyc;
      exp_to_edge = TO_ON ? cyc + TB_TIMEOUT : -1;
      if (clr) begin
        m_rdy = 1'b0;
        m_ovr = 1'b0;
      end
    end else begin
      have_hi     = 1'b0;
      m_cmd       = {m_hi, b};
      m_ovr       = m_rdy;
      m_rdy       = 1'b1;
      exp_to_edge = -1;
      exp_q.push_back({m_ovr, m_cmd});
    end
  endtask

  task automatic clear_cmd();
    bus_if.clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1;
    bus_if.clr_cmd_rdy = 1'b0;
    m_rdy = 1'b0;
    m_ovr = 1'b0;
    check("clear_cmd_rdy", 32'(bus_if.cmd_rdy), 32'(m_rdy));
    check("clear_cmd_ovr", 32'(bus_if.cmd_ovr), 32'(m_ovr));
    check("clear_cmd_hold", 32'(bus_if.cmd), 32'(m_cmd));
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    bus_if.rx_data = 8'h55;
    bus_if.rx_rdy  = 1'b1;    // ack must stay low while in reset
    #2;
    check("rst_cmd", 32'(bus_if.cmd), 32'h0000);
    check("rst_cmd_rdy", 32'(bus_if.cmd_rdy), 32'd0);
    check("rst_cmd_ovr", 32'(bus_if.cmd_ovr), 32'd0);
    check("rst_cmd_to", 32'(bus_if.cmd_to), 32'd0);
    check("rst_clr_rx_rdy", 32'(bus_if.clr_rx_rdy), 32'd0);
    check("rst_state", 32'(bus_if.state_dbg), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    bus_if.rx_rdy = 1'b0;
    rst_n         = 1'b1;
    have_hi       = 1'b0;
    m_cmd         = 16'h0000;
    m_rdy         = 1'b0;
    m_ovr         = 1'b0;
    exp_to_edge   = -1;
    exp_q.delete();
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit          pending = 1'b0;
  logic [16:0] exp_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      pending = 1'b0;
    end else begin
      check("clr_rx_rdy", 32'(bus_if.clr_rx_rdy), 32'(bus_if.rx_rdy));
      check("cmd_to", 32'(bus_if.cmd_to), 32'(cyc == exp_to_edge));
      if (pending) begin
        if (exp_q.size() == 0) begin
          check("unexpected_cmd", 32'(bus_if.cmd), 32'hFFFF_FFFF);
        end else begin
          exp_e = exp_q.pop_front();
          check("cmd", 32'(bus_if.cmd), 32'(exp_e[15:0]));
          check("cmd_rdy", 32'(bus_if.cmd_rdy), 32'd1);
          check("cmd_ovr", 32'(bus_if.cmd_ovr), 32'(exp_e[16]));
        end
      end
      // A byte sampled while waiting for the low byte completes a command.
      pending = bus_if.rx_rdy && bus_if.state_dbg;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus_if.rx_data     = 8'h00;
    bus_if.rx_rdy      = 1'b0;
    bus_if.clr_cmd_rdy = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Basic assembly and handshake
    send_byte(8'hA5, 1'b0);
    send_byte(8'h3C, 1'b0);
    idle(1);
    clear_cmd();

    // Overrun
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    idle(2);
    send_byte(8'h56, 1'b0);
    send_byte(8'h78, 1'b0);
    idle(1);
    clear_cmd();

    // Simultaneous set/clear
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b1);
    idle(1);
    check("setclr_rdy", 32'(bus_if.cmd_rdy), 32'd1);
    check("setclr_cmd", 32'(bus_if.cmd), 32'h00FF);

    // Reset mid-command
    send_byte(8'hAA, 1'b0);
    do_reset();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    idle(1);
    check("post_reset_cmd", 32'(bus_if.cmd), 32'h1122);
    clear_cmd();

`ifdef CMD_TIMEOUT_EN
    // Timeout discards the high byte
    send_byte(8'hAA, 1'b0);
    idle(TB_TIMEOUT);
    check("to_pulse", 32'(bus_if.cmd_to), 32'd1);
    check("to_state", 32'(bus_if.state_dbg), 32'd0);
    check("to_cmd_rdy", 32'(bus_if.cmd_rdy), 32'd0);
    idle(1);
    check("to_pulse_end", 32'(bus_if.cmd_to), 32'd0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    idle(1);
    check("to_after_cmd", 32'(bus_if.cmd), 32'h1122);
    clear_cmd();
    // Low byte exactly at terminal count wins
    send_byte(8'hAA, 1'b0);
    idle(TB_TIMEOUT - 1);
    send_byte(8'h22, 1'b0);
    check("term_cmd_to", 32'(bus_if.cmd_to), 32'd0);
    check("term_cmd", 32'(bus_if.cmd), 32'hAA22);
    clear_cmd();
`else
    // Without the timeout, LOW waits indefinitely
    send_byte(8'hAA, 1'b0);
    idle(40);
    check("no_to_state", 32'(bus_if.state_dbg), 32'd1);
    send_byte(8'h22, 1'b0);
    check("no_to_cmd", 32'(bus_if.cmd), 32'hAA22);
    clear_cmd();
`endif

    // Randomized stream: back-to-back bytes, gaps, clears
    for (int i = 0; i < 400; i++) begin
      send_byte(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 7) == 0) idle($urandom_range(TB_TIMEOUT - 2, TB_TIMEOUT + 2));
      else if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) clear_cmd();
    end

    idle(TB_TIMEOUT + 4);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
